bus_fifo_slave: RTL and testbench

//  Bus slave (responder) on the arbitrated intf bus: a mailbox FIFO that masters write into and read out of.
//  - Connects to a slave modport: addr, wdata, RE, WE in; rdata out.
//  - Gives data_gen/master a decoupled queue instead of fixed RAM addresses.
//  - Raises irq when occupancy reaches a threshold.

---
 rtl/bus_fifo_slave.sv | 99 +++++++++
 tb/tb_bus_fifo_slave.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/bus_fifo_slave.sv
// Mailbox FIFO bus slave: DATA/STAT/CTRL/FLAG registers on addr[1:0],
// registered read data and an occupancy-threshold interrupt.
module bus_fifo_slave #(
  parameter int asize  = 7,
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 8,
  parameter int THRESH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [asize-1:0]  addr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              RE,
  input  logic              WE,
  output logic [DWIDTH-1:0] rdata,
  output logic              irq
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_ovf, r_unf;

  logic [1:0]        w_sel;
  logic              w_rd_data, w_wr_data, w_full, w_empty;
  logic              w_pop, w_push, w_flush, w_flag_rd;
  logic              w_ovf_evt, w_unf_evt;
  logic [CW-1:0]     w_count_nxt;
  logic [7:0]        w_stat8;
  logic [DWIDTH-1:0] w_rdata_nxt;
  logic              w_unused;

  // Upper address bits alias onto the four registers.
  assign w_unused  = ^addr[asize-1:2];
  assign w_sel     = addr[1:0];
  assign w_rd_data = RE && (w_sel == 2'd0);
  assign w_wr_data = WE && (w_sel == 2'd0);
  assign w_flag_rd = RE && (w_sel == 2'd3);
  assign w_flush   = WE && (w_sel == 2'd2) && wdata[0];
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop     = w_rd_data && !w_empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO is legal then.
  assign w_push    = w_wr_data && (!w_full || w_pop);
  assign w_ovf_evt = w_wr_data && !w_push;
  assign w_unf_evt = w_rd_data && w_empty;
  assign w_stat8   = {w_full, w_empty, irq, 5'(r_count)};

  always_comb begin
    w_count_nxt = r_count;
    if (w_flush)              w_count_nxt = '0;
    else if (w_push && !w_pop) w_count_nxt = r_count + CW'(1);
    else if (w_pop && !w_push) w_count_nxt = r_count - CW'(1);
  end

  always_comb begin
    w_rdata_nxt = '0;
    case (w_sel)
      2'd0:    w_rdata_nxt = w_pop ? r_mem[r_rd_ptr] : '0;
      2'd1:    w_rdata_nxt = DWIDTH'(w_stat8);
      2'd3:    w_rdata_nxt = DWIDTH'({r_unf, r_ovf});
      default: w_rdata_nxt = '0;
    endcase
  end

  // Storage is never cleared; the reset guard blocks a write on an edge during reset.
  always_ff @(posedge clk) begin
    if (reset && w_push) r_mem[r_wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      rdata    <= '0;
      irq      <= 1'b0;
    end else begin
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= w_count_nxt;
      // A new event in the same cycle as the clearing read keeps the flag set.
      r_ovf   <= w_ovf_evt | (r_ovf & ~w_flag_rd);
      r_unf   <= w_unf_evt | (r_unf & ~w_flag_rd);
      if (RE) rdata <= w_rdata_nxt;
      irq     <= (w_count_nxt >= CW'(THRESH));
    end
  end

endmodule

// File: tb/tb_bus_fifo_slave.sv
// Self-checking bench for bus_fifo_slave: a vector table for the basic
// register behaviour plus hand sequences for simultaneous access, flush and reset.
module tb_bus_fifo_slave;
  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       RE, WE;
  logic [7:0] rdata;
  logic       irq;

  typedef struct {
    bit         re;
    bit         we;
    logic [1:0] a;
    logic [7:0] wd;
    bit         chk_rd;
    logic [7:0] exp_rd;
    bit         chk_irq;
    bit         exp_irq;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  bus_fifo_slave #(.asize(7), .DWIDTH(8), .DEPTH(8), .THRESH(4)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
    .RE(RE), .WE(WE), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic add(input bit re, input bit we, input logic [1:0] a, input logic [7:0] wd,
                     input bit chk_rd, input logic [7:0] exp_rd, input bit chk_irq, input bit exp_irq);
    vec_t v;
    v.re = re; v.we = we; v.a = a; v.wd = wd;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.chk_irq = chk_irq; v.exp_irq = exp_irq;
    vecs.push_back(v);
  endtask

  // One bus cycle: drive on negedge, expected read data queued, compared after the edge.
  task automatic bus(input string name, input bit re, input bit we, input logic [1:0] a,
                     input logic [7:0] wd, input bit chk_rd, input logic [7:0] exp_rd,
                     input bit chk_irq, input bit exp_irq);
    logic [7:0] exp;
    @(negedge clk);
    RE = re; WE = we; addr = {5'b10101, a}; wdata = wd;
    if (chk_rd) sb_q.push_back(exp_rd);
    @(posedge clk);
    #1;
    RE = 1'b0; WE = 1'b0;
    if (chk_rd) begin
      exp = sb_q.pop_front();
      check({name, " rdata"}, rdata, exp);
    end
    if (chk_irq) check({name, " irq"}, {7'b0, irq}, {7'b0, exp_irq});
  endtask

  initial begin
    reset = 1'b0; RE = 1'b0; WE = 1'b0; addr = '0; wdata = '0;

    // T1: idle
    add(1, 0, 2'd1, 8'h00, 1, 8'h40, 1, 0);
    add(1, 0, 2'd3, 8'h00, 1, 8'h00, 0, 0);
    // T2: order and irq
    add(0, 1, 2'd0, 8'h11, 0, 8'h00, 1, 0);
    add(0, 1, 2'd0, 8'h22, 0, 8'h00, 1, 0);
    add(0, 1, 2'd0, 8'h33, 0, 8'h00, 1, 0);
    add(0, 1, 2'd0, 8'h44, 0, 8'h00, 1, 1);
    add(1, 0, 2'd0, 8'h00, 1, 8'h11, 1, 0);
    add(1, 0, 2'd0, 8'h00, 1, 8'h22, 0, 0);
    add(1, 0, 2'd0, 8'h00, 1, 8'h33, 0, 0);
    add(1, 0, 2'd0, 8'h00, 1, 8'h44, 1, 0);
    // T3: full and overflow
    for (int i = 1; i <= 9; i++) add(0, 1, 2'd0, 8'(i), 0, 8'h00, 1, i >= 4);
    add(1, 0, 2'd1, 8'h00, 1, 8'hA8, 1, 1);
    add(1, 0, 2'd3, 8'h00, 1, 8'h01, 0, 0);
    add(1, 0, 2'd3, 8'h00, 1, 8'h00, 0, 0);
    for (int i = 1; i <= 8; i++) add(1, 0, 2'd0, 8'h00, 1, 8'(i), 1, i <= 4);
    add(1, 0, 2'd1, 8'h00, 1, 8'h40, 0, 0);
    // T4: empty and underflow
    add(1, 0, 2'd0, 8'h00, 1, 8'h00, 1, 0);
    add(1, 0, 2'd1, 8'h00, 1, 8'h40, 0, 0);
    add(1, 0, 2'd3, 8'h00, 1, 8'h02, 0, 0);
    add(1, 0, 2'd3, 8'h00, 1, 8'h00, 0, 0);
    add(1, 0, 2'd2, 8'h00, 1, 8'h00, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("reset rdata", rdata, 8'h00);
    check("reset irq", {7'b0, irq}, 8'h00);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i])
      bus($sformatf("vec%0d", i), vecs[i].re, vecs[i].we, vecs[i].a, vecs[i].wd,
          vecs[i].chk_rd, vecs[i].exp_rd, vecs[i].chk_irq, vecs[i].exp_irq);

    // T5: simultaneous push/pop on a full FIFO, then on an empty one
    for (int i = 0; i < 8; i++) bus("t5 fill", 0, 1, 2'd0, 8'hB0 + 8'(i), 0, 8'h00, 1, i >= 3);
    bus("t5 rw full", 1, 1, 2'd0, 8'hAA, 1, 8'hB0, 1, 1);
    bus("t5 stat", 1, 0, 2'd1, 8'h00, 1, 8'hA8, 0, 0);
    bus("t5 flag", 1, 0, 2'd3, 8'h00, 1, 8'h00, 0, 0);
    for (int k = 1; k <= 7; k++) bus($sformatf("t5 pop%0d", k), 1, 0, 2'd0, 8'h00, 1, 8'hB0 + 8'(k), 1, k <= 4);
    bus("t5 pop8", 1, 0, 2'd0, 8'h00, 1, 8'hAA, 1, 0);
    bus("t5 stat empty", 1, 0, 2'd1, 8'h00, 1, 8'h40, 0, 0);
    bus("t5 rw empty", 1, 1, 2'd0, 8'h5C, 1, 8'h00, 1, 0);
    bus("t5 stat one", 1, 0, 2'd1, 8'h00, 1, 8'h01, 0, 0);
    bus("t5 flag unf", 1, 0, 2'd3, 8'h00, 1, 8'h02, 0, 0);
    bus("t5 pop 5c", 1, 0, 2'd0, 8'h00, 1, 8'h5C, 0, 0);

    // T6: flush keeps flags, then asynchronous reset mid-cycle
    bus("t6 unf", 1, 0, 2'd0, 8'h00, 1, 8'h00, 0, 0);
    for (int i = 1; i <= 5; i++) bus("t6 fill", 0, 1, 2'd0, 8'hC0 + 8'(i), 0, 8'h00, 1, i >= 4);
    bus("t6 stat5", 1, 0, 2'd1, 8'h00, 1, 8'h25, 0, 0);
    bus("t6 ctrl0", 0, 1, 2'd2, 8'h00, 0, 8'h00, 1, 1);
    bus("t6 stat5b", 1, 0, 2'd1, 8'h00, 1, 8'h25, 0, 0);
    bus("t6 flush", 0, 1, 2'd2, 8'h01, 0, 8'h00, 1, 0);
    bus("t6 stat flushed", 1, 0, 2'd1, 8'h00, 1, 8'h40, 0, 0);
    bus("t6 flag kept", 1, 0, 2'd3, 8'h00, 1, 8'h02, 0, 0);
    for (int i = 1; i <= 5; i++) bus("t6 refill", 0, 1, 2'd0, 8'hD0 + 8'(i), 0, 8'h00, 0, 0);
    bus("t6 pop d1", 1, 0, 2'd0, 8'h00, 1, 8'hD1, 1, 1);

    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async rdata", rdata, 8'h00);
    check("async irq", {7'b0, irq}, 8'h00);
    @(negedge clk);
    WE = 1'b1; addr = '0; wdata = 8'hEE;
    @(posedge clk);
    #1;
    WE = 1'b0;
    check("in-reset rdata", rdata, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    bus("post flag", 1, 0, 2'd3, 8'h00, 1, 8'h00, 1, 0);
    bus("post stat", 1, 0, 2'd1, 8'h00, 1, 8'h40, 0, 0);
    bus("post pop", 1, 0, 2'd0, 8'h00, 1, 8'h00, 0, 0);

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: %0d left, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time %0t exceeded", $time);
    $fatal(1);
  end
endmodule
